// File: rtl/mdu_sequencer_if.sv
// Bus between the EX stage and the multiply/divide sequencer.
//   Launch side : start, funct3, rs1, rs2, flush  (EX -> sequencer)
//   Status side : busy, done, result              (sequencer -> EX)
//   ALU borrow  : alu_req, alu_a, alu_b, alu_fn   (sequencer -> EX/ALU)
//                 alu_r, alu_cf                   (ALU -> sequencer, same cycle)
// Modports: master = EX stage / ALU side, slave = the sequencer.
interface mdu_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            alu_req;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_fn;
  logic [XLEN-1:0] alu_r;
  logic            alu_cf;

  modport master (
    output start, funct3, rs1, rs2, flush, alu_r, alu_cf,
    input  busy, done, result, alu_req, alu_a, alu_b, alu_fn
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush, alu_r, alu_cf,
    output busy, done, result, alu_req, alu_a, alu_b, alu_fn
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Borrows the shared ALU adder for one add/sub per cycle: shift-add multiply and
// restoring divide. Handles sign fix-up and the RISC-V divide special cases.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mdu_sequencer_if.slave: start/funct3/rs1/rs2/flush in, busy/done/result out,
//          alu_req/alu_a/alu_b/alu_fn out, alu_r/alu_cf in
// Build option: define MDU_EARLY_OUT_EN to let multiplies leave ITER as soon as the
// remaining multiplier bits are zero (result unchanged, latency shorter).
module mdu_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input logic            clk,
  input logic            rst,
  mdu_sequencer_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [3:0]  AluAdd = 4'b0000;
  localparam logic [3:0]  AluSub = 4'b0001;
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opa_q, opa_d;    // rs1, then multiplicand / dividend magnitude
  logic [XLEN-1:0]   opb_q, opb_d;    // rs2, then multiplier / divisor magnitude
  logic [XLEN-1:0]   hi_q, hi_d;      // product high word / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;      // multiplier+product low word / quotient
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_q, neg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Operation decode
  logic is_div, is_rem, sgn1_en, sgn2_en, s1, s2;
  assign is_div  = op_q[2];
  assign is_rem  = op_q[2] & op_q[1];
  assign sgn1_en = is_div ? ~op_q[0] : ((op_q == 3'd1) || (op_q == 3'd2));
  assign sgn2_en = is_div ? ~op_q[0] : (op_q == 3'd1);
  assign s1      = sgn1_en & opa_q[XLEN-1];
  assign s2      = sgn2_en & opb_q[XLEN-1];

  logic [XLEN-1:0] mag1, mag2;
  assign mag1 = s1 ? -opa_q : opa_q;
  assign mag2 = s2 ? -opb_q : opb_q;

  logic div_zero, div_ovf;
  assign div_zero = is_div && (opb_q == '0);
  assign div_ovf  = is_div && !op_q[0] && (opa_q == MinInt) && (opb_q == '1);

  // Divide step: {div_msb, div_p} is the 33-bit partial remainder shifted left by one
  logic            div_msb;
  logic [XLEN-1:0] div_p;
  assign div_msb = hi_q[XLEN-1];
  assign div_p   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};

  // Multiply step: {cf, r, lo} >> 1
  logic [2*XLEN-1:0] mul_shift;
  assign mul_shift = {bus.alu_cf, bus.alu_r, lo_q[XLEN-1:1]};

`ifdef MDU_EARLY_OUT_EN
  // Multiplier bits not yet consumed after this step sit in lo[XLEN-1-cnt:1]
  logic [XLEN-1:0] early_mask;
  logic            mul_early;
  assign early_mask = {1'b0, {(XLEN-1){1'b1}}} >> cnt_q;
  assign mul_early  = ((lo_q >> 1) & early_mask) == '0;
`endif

  // Sign fix-up with local negators; the ALU is not borrowed here
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_res, div_res_s, fix_result;
  always_comb begin
    prod      = {hi_q, lo_q};
    prod_s    = neg_q ? -prod : prod;
    div_res   = is_rem ? hi_q : lo_q;
    div_res_s = neg_q ? -div_res : div_res;
    if (is_div) begin
      fix_result = div_res_s;
    end else if (op_q == 3'd0) begin
      fix_result = prod_s[XLEN-1:0];
    end else begin
      fix_result = prod_s[2*XLEN-1:XLEN];
    end
  end

  // ALU borrow, only while iterating
  always_comb begin
    bus.alu_req = 1'b0;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_fn  = AluAdd;
    if (state_q == StIter) begin
      bus.alu_req = 1'b1;
      if (is_div) begin
        bus.alu_a  = div_p;
        bus.alu_b  = opb_q;
        bus.alu_fn = AluSub;
      end else begin
        bus.alu_a = hi_q;
        bus.alu_b = lo_q[0] ? opa_q : '0;
      end
    end
  end

  assign bus.busy   = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
  // A flush in DONE comes too late: the op has already retired.
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          op_d    = bus.funct3;
          opa_d   = bus.rs1;
          opb_d   = bus.rs2;
          state_d = StPrep;
        end
      end
      StPrep: begin
        neg_d = is_rem ? s1 : (s1 ^ s2);
        opa_d = mag1;
        opb_d = mag2;
        hi_d  = '0;
        lo_d  = is_div ? mag1 : mag2;
        cnt_d = '0;
        if (div_zero) begin
          result_d = is_rem ? opa_q : '1;
          state_d  = StDone;
        end else if (div_ovf) begin
          result_d = is_rem ? '0 : MinInt;
          state_d  = StDone;
        end else begin
          state_d = StIter;
`ifdef MDU_EARLY_OUT_EN
          if (!is_div && (mag2 == '0)) state_d = StFix;
`endif
        end
      end
      StIter: begin
        cnt_d = cnt_q + CntW'(1);
        if (is_div) begin
          // A 33-bit overflow always exceeds the divisor; mod-2^32 ALU result is exact
          if (div_msb || bus.alu_cf) begin
            hi_d = bus.alu_r;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_p;
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          {hi_d, lo_d} = mul_shift;
        end
        if (cnt_q == '1) state_d = StFix;
`ifdef MDU_EARLY_OUT_EN
        // Remaining steps would add zero, so they collapse into one plain shift
        if (!is_div && mul_early) begin
          {hi_d, lo_d} = mul_shift >> (~cnt_q);
          cnt_d        = '0;
          state_d      = StFix;
        end
`endif
      end
      StFix: begin
        result_d = fix_result;
        state_d  = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush && (state_q != StIdle)) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: the driver pushes expected result, completion
// cycle and ALU-borrow count per op; a negedge monitor pops and compares on done.
module tb_mdu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
    int          alus;
  } exp_t;

  exp_t        sb[$];
  int          alu_cnt = 0;
  logic [31:0] last_res = '0;

  mdu_sequencer_if #(.XLEN(32)) bus ();

  mdu_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU: add returns carry-out, sub returns "no borrow"
  always_comb begin
    if (bus.alu_fn == 4'b0001) begin
      bus.alu_r  = bus.alu_a - bus.alu_b;
      bus.alu_cf = (bus.alu_a >= bus.alu_b);
    end else begin
      {bus.alu_cf, bus.alu_r} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, b);
    if (!op[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, b);
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    int     ia = a;
    int     ib = b;
    logic [63:0] p;
    case (op)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (is_special(op, a, b)) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (is_special(op, a, b)) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Number of significant bits in the multiplier magnitude
  function automatic int sig_bits(input logic [2:0] op, input logic [31:0] b);
    logic [31:0] m = (op == 3'd1 && b[31]) ? -b : b;
    int n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
  endfunction

  function automatic int ref_alus(input logic [2:0] op, input logic [31:0] a, b);
    if (is_special(op, a, b)) return 0;
`ifdef MDU_EARLY_OUT_EN
    if (!op[2]) return sig_bits(op, b);
`endif
    return 32;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, b);
    return is_special(op, a, b) ? 2 : 3 + ref_alus(op, a, b);
  endfunction

  // ---------------- driver helpers ----------------
  task automatic wait_idle();
    int k = 0;
    while ((bus.busy || bus.done) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: busy=%b done=%b after 100 cycles, expected idle", bus.busy, bus.done);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, b, input bit push);
    exp_t e;
    wait_idle();
    bus.start  = 1'b1;
    bus.funct3 = op;
    bus.rs1    = a;
    bus.rs2    = b;
    if (push) begin
      e.res  = ref_res(op, a, b);
      e.due  = cyc + ref_lat(op, a, b);
      e.alus = ref_alus(op, a, b);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.rs1    = $urandom;
    bus.rs2    = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.alu_req) alu_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: result %h with empty scoreboard, expected no done", bus.result);
        end else begin
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("latency", cyc, e.due);
          chk("alu_cycles", alu_cnt, e.alus);
          chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
          last_res = e.res;
        end
        alu_cnt = 0;
      end else if (!bus.busy) begin
        alu_cnt = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t dir[$] = '{
    '{3'd0, 32'd7,          32'd6},
    '{3'd1, 32'hFFFF_FFFF,  32'd2},
    '{3'd3, 32'hFFFF_FFFF,  32'd2},
    '{3'd2, 32'hFFFF_FFFE,  32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9,  32'd2},
    '{3'd6, 32'hFFFF_FFF9,  32'd2},
    '{3'd5, 32'hFFFF_FFFF,  32'hFFFF_FFFE},
    '{3'd4, 32'd5,          32'd0},
    '{3'd6, 32'd5,          32'd0},
    '{3'd7, 32'd9,          32'd0},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF},
    '{3'd0, 32'd9,          32'd3},
    '{3'd0, 32'h1234_5678,  32'd0},
    '{3'd7, 32'h8000_0000,  32'h8000_0000}
  };

  initial begin
    int seen;
    int k;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.rs1    = '0;
    bus.rs2    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("rst_done",    {31'd0, bus.done},    32'd0);
    chk("rst_result",  bus.result,           32'd0);
    chk("rst_alu_req", {31'd0, bus.alu_req}, 32'd0);
    chk("rst_alu_a",   bus.alu_a,            32'd0);
    chk("rst_alu_b",   bus.alu_b,            32'd0);
    chk("rst_alu_fn",  {28'd0, bus.alu_fn},  32'd0);

    foreach (dir[i]) start_op(dir[i].op, dir[i].a, dir[i].b, 1'b1);
    wait_idle();

    // Flush and start together in IDLE: not accepted
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd5; bus.rs1 = 32'd50; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_busy", {31'd0, bus.busy}, 32'd0);

    // Start while busy is ignored
    start_op(3'd5, 32'd1000, 32'd7, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();

    // Reset in the middle of an op: no done afterwards
    start_op(3'd3, 32'hDEAD_BEEF, 32'h8000_0000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("midrst_result", bus.result,        32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    chk("midrst_no_done", seen, 32'd0);

    // Give the result register a known value, then flush at ITER cycle 10
    start_op(3'd0, 32'd11, 32'd13, 1'b1);
    wait_idle();
    start_op(3'd3, 32'hCAFE_F00D, 32'h8000_0001, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    chk("flush_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy",   {31'd0, bus.busy}, 32'd0);
    chk("flush_done",   {31'd0, bus.done}, 32'd0);
    chk("flush_result", bus.result,        last_res);
    start_op(3'd4, 32'hFFFF_FF00, 32'd16, 1'b1);
    wait_idle();

    for (int i = 0; i < 1200; i++) begin
      start_op(3'($urandom), pick(), pick(), 1'b1);
    end
    wait_idle();

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
